// File: rtl/uarch_pkg.sv
// Shared micro-architecture types and constants for the front end.
package uarch_pkg;

  localparam int CPU_ADDR_BITS = 32;
  localparam int CPU_INST_BITS = 32;

  // ADDI x0,x0,0
  localparam logic [CPU_INST_BITS-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [CPU_ADDR_BITS-1:0] pc;
    logic [CPU_INST_BITS-1:0] slot0;
    logic [CPU_INST_BITS-1:0] slot1;
  } fb_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Instruction-pair FIFO between fetch and decode with first-word-fall-through output.
// Optional same-cycle bypass when empty: define FETCH_BUFFER_BYPASS_EN.
module fetch_buffer
  import uarch_pkg::*;
#(
  parameter int                       FB_DEPTH = 4,
  parameter logic [CPU_INST_BITS-1:0] NOP_INST = INST_NOP
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          fetch_val,
  output logic                          fetch_rdy,
  input  logic [CPU_ADDR_BITS-1:0]      fetch_pc,
  input  logic [CPU_INST_BITS-1:0]      fetch_inst0,
  input  logic [CPU_INST_BITS-1:0]      fetch_inst1,
  input  logic [1:0]                    fetch_mask,
  input  logic                          decode_rdy,
  output logic                          inst_val,
  output logic [CPU_ADDR_BITS-1:0]      inst0_pc,
  output logic [CPU_ADDR_BITS-1:0]      inst1_pc,
  output logic [CPU_INST_BITS-1:0]      inst0,
  output logic [CPU_INST_BITS-1:0]      inst1,
  output logic [$clog2(FB_DEPTH):0]     fb_count
);

  localparam int IW = $clog2(FB_DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  fb_entry_t     r_mem [FB_DEPTH];

  logic      w_empty;
  logic      w_full;
  logic      w_enq;
  logic      w_write;
  logic      w_deq;
  logic      w_bypass;
  fb_entry_t w_new;
  fb_entry_t w_head;
  fb_entry_t w_out;

  // Left-justify a half group so slot 0 always holds the oldest valid instruction.
  function automatic fb_entry_t form_entry(
    input logic [CPU_ADDR_BITS-1:0] pc,
    input logic [CPU_INST_BITS-1:0] i0,
    input logic [CPU_INST_BITS-1:0] i1,
    input logic [1:0]               mask
  );
    fb_entry_t e;
    case (mask)
      2'b10: begin
        e.pc    = pc + CPU_ADDR_BITS'(4);
        e.slot0 = i1;
        e.slot1 = NOP_INST;
      end
      2'b01: begin
        e.pc    = pc;
        e.slot0 = i0;
        e.slot1 = NOP_INST;
      end
      default: begin
        e.pc    = pc;
        e.slot0 = i0;
        e.slot1 = i1;
      end
    endcase
    return e;
  endfunction

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]) && (r_wr_ptr[IW] != r_rd_ptr[IW]);
  assign w_enq   = fetch_val && !w_full && (fetch_mask != 2'b00) && !flush;
  assign w_new   = form_entry(fetch_pc, fetch_inst0, fetch_inst1, fetch_mask);
  assign w_head  = r_mem[r_rd_ptr[IW-1:0]];

`ifdef FETCH_BUFFER_BYPASS_EN
  assign w_bypass = w_empty && w_enq;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed group taken by decode in the same cycle never touches storage.
  assign w_write = w_enq && !(w_bypass && decode_rdy);
  assign w_deq   = !w_empty && decode_rdy;
  assign w_out   = w_bypass ? w_new : w_head;

  assign inst_val  = !w_empty || w_bypass;
  assign inst0_pc  = w_out.pc;
  assign inst1_pc  = w_out.pc + CPU_ADDR_BITS'(4);
  assign inst0     = w_out.slot0;
  assign inst1     = w_out.slot1;
  assign fetch_rdy = !w_full;
  assign fb_count  = r_wr_ptr - r_rd_ptr;

  // Pointer update; flush outranks any same-cycle enqueue or dequeue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_deq)   r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Payload storage; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr[IW-1:0]] <= w_new;
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: stimulus pushes expected pairs, a monitor pops on handshake.
module tb_fetch_buffer;
  import uarch_pkg::*;

  localparam int DEPTH = 4;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     flush = 1'b0;
  logic                     fetch_val = 1'b0;
  logic                     fetch_rdy;
  logic [CPU_ADDR_BITS-1:0] fetch_pc = '0;
  logic [CPU_INST_BITS-1:0] fetch_inst0 = '0;
  logic [CPU_INST_BITS-1:0] fetch_inst1 = '0;
  logic [1:0]               fetch_mask = 2'b00;
  logic                     decode_rdy = 1'b0;
  logic                     inst_val;
  logic [CPU_ADDR_BITS-1:0] inst0_pc;
  logic [CPU_ADDR_BITS-1:0] inst1_pc;
  logic [CPU_INST_BITS-1:0] inst0;
  logic [CPU_INST_BITS-1:0] inst1;
  logic [$clog2(DEPTH):0]   fb_count;

  int n_cmp = 0;
  int n_err = 0;
  fb_entry_t exp_q[$];

  fetch_buffer #(.FB_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .fetch_val(fetch_val), .fetch_rdy(fetch_rdy), .fetch_pc(fetch_pc),
    .fetch_inst0(fetch_inst0), .fetch_inst1(fetch_inst1), .fetch_mask(fetch_mask),
    .decode_rdy(decode_rdy), .inst_val(inst_val),
    .inst0_pc(inst0_pc), .inst1_pc(inst1_pc), .inst0(inst0), .inst1(inst1),
    .fb_count(fb_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every handshake must match the oldest expected pair.
  always @(negedge clk) begin
    if (rst_n && inst_val && decode_rdy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pair: got pc %h inst0 %h, expected nothing", inst0_pc, inst0);
      end else begin
        fb_entry_t e;
        e = exp_q.pop_front();
        chk("inst0_pc", 64'(inst0_pc), 64'(e.pc));
        chk("inst1_pc", 64'(inst1_pc), 64'(e.pc + 32'd4));
        chk("inst0", 64'(inst0), 64'(e.slot0));
        chk("inst1", 64'(inst1), 64'(e.slot1));
      end
    end
  end

  // Drive one group for one cycle; expected pair is hand-supplied.
  task automatic send(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [1:0] mask, input fb_entry_t e);
    fetch_val = 1'b1;
    fetch_pc = pc;
    fetch_inst0 = i0;
    fetch_inst1 = i1;
    fetch_mask = mask;
    if (fetch_rdy && mask != 2'b00 && !flush) exp_q.push_back(e);
    @(posedge clk);
    #1;
    fetch_val = 1'b0;
  endtask

  // Retry a group until the buffer takes it.
  task automatic send_wait(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1,
                           input fb_entry_t e);
    int k;
    k = 0;
    fetch_val = 1'b1;
    fetch_pc = pc;
    fetch_inst0 = i0;
    fetch_inst1 = i1;
    fetch_mask = 2'b11;
    while (!fetch_rdy && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("send_wait_timeout", 64'(fetch_rdy), 64'd1);
    if (fetch_rdy) exp_q.push_back(e);
    @(posedge clk);
    #1;
    fetch_val = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 30) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2;
    chk("rst_inst_val", 64'(inst_val), 64'd0);
    chk("rst_fetch_rdy", 64'(fetch_rdy), 64'd1);
    chk("rst_fb_count", 64'(fb_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full pair, consumed immediately
    decode_rdy = 1'b1;
    send(32'h100, 32'h0050_0093, 32'h00A0_0113, 2'b11, '{32'h100, 32'h0050_0093, 32'h00A0_0113});
`ifdef FETCH_BUFFER_BYPASS_EN
    chk("t1_val", 64'(inst_val), 64'd0);
    chk("t1_cnt", 64'(fb_count), 64'd0);
`else
    chk("t1_val", 64'(inst_val), 64'd1);
    chk("t1_cnt", 64'(fb_count), 64'd1);
    @(posedge clk);
    #1;
    chk("t1_val_after", 64'(inst_val), 64'd0);
`endif
    chk("t1_consumed", 64'(exp_q.size()), 64'd0);

    // Upper-half-only group is left-justified and padded
    send(32'h208, 32'hDEAD_BEEF, 32'h0010_8093, 2'b10, '{32'h20C, 32'h0010_8093, 32'h0000_0013});
    drain();
    // Lower-half-only group keeps its PC and pads slot 1
    send(32'h300, 32'h1234_5678, 32'hCAFE_F00D, 2'b01, '{32'h300, 32'h1234_5678, 32'h0000_0013});
    drain();
    // Empty mask is consumed but never presented
    send(32'h400, 32'h1111_1111, 32'h2222_2222, 2'b00, '{32'h0, 32'h0, 32'h0});
    chk("mask00_val", 64'(inst_val), 64'd0);
    chk("mask00_cnt", 64'(fb_count), 64'd0);

    // Fill to full with decode stalled, then drain across the pointer wrap
    decode_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(32'h1000 + 32'(i * 8), 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i), 2'b11,
           '{32'h1000 + 32'(i * 8), 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)});
    end
    chk("full_cnt", 64'(fb_count), 64'd4);
    chk("full_rdy", 64'(fetch_rdy), 64'd0);
    chk("full_head_pc", 64'(inst0_pc), 64'h1000);
    decode_rdy = 1'b1;
    send_wait(32'h1020, 32'hA000_0004, 32'hB000_0004, '{32'h1020, 32'hA000_0004, 32'hB000_0004});
    drain();
    @(posedge clk);
    #1;
    chk("drained_cnt", 64'(fb_count), 64'd0);

    // Flush a full buffer while a group is offered
    decode_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(32'h2000 + 32'(i * 8), 32'hC000_0000 + 32'(i), 32'hD000_0000 + 32'(i), 2'b11,
           '{32'h2000 + 32'(i * 8), 32'hC000_0000 + 32'(i), 32'hD000_0000 + 32'(i)});
    end
    chk("pre_flush_cnt", 64'(fb_count), 64'd4);
    flush = 1'b1;
    send(32'h2F00, 32'hEEEE_EEEE, 32'hFFFF_FFFF, 2'b11, '{32'h0, 32'h0, 32'h0});
    flush = 1'b0;
    exp_q.delete();
    chk("flush_cnt", 64'(fb_count), 64'd0);
    chk("flush_val", 64'(inst_val), 64'd0);
    chk("flush_rdy", 64'(fetch_rdy), 64'd1);
    decode_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Streaming at one group per cycle
    for (int i = 0; i < 7; i++) begin
      send(32'h3000 + 32'(i * 8), 32'h5000_0000 + 32'(i), 32'h6000_0000 + 32'(i), 2'b11,
           '{32'h3000 + 32'(i * 8), 32'h5000_0000 + 32'(i), 32'h6000_0000 + 32'(i)});
`ifdef FETCH_BUFFER_BYPASS_EN
      chk("stream_cnt", 64'(fb_count), 64'd0);
`else
      chk("stream_cnt", 64'(fb_count), 64'd1);
`endif
    end
    drain();

    // Asynchronous reset with three entries held
    decode_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(32'h4000 + 32'(i * 8), 32'h7000_0000 + 32'(i), 32'h8000_0000 + 32'(i), 2'b11,
           '{32'h4000 + 32'(i * 8), 32'h7000_0000 + 32'(i), 32'h8000_0000 + 32'(i)});
    end
    chk("pre_rst_cnt", 64'(fb_count), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_val", 64'(inst_val), 64'd0);
    chk("async_rst_cnt", 64'(fb_count), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    decode_rdy = 1'b1;
    send(32'h600, 32'h9999_0001, 32'h9999_0002, 2'b11, '{32'h600, 32'h9999_0001, 32'h9999_0002});
    drain();
    repeat (2) @(posedge clk);
    #1;
    chk("final_cnt", 64'(fb_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction-pair FIFO between I-cache/fetch and decode; it is the producer side of the decode handshake (inst0/inst1, inst0_pc/inst1_pc, inst_val, decode_rdy).
- Accepts one aligned 8-byte fetch group per cycle. Left-justifies a group entered mid-pair and pads the empty slot with a NOP.
- Presents the oldest pair first-word-fall-through. Drops all contents on flush.

Parameters:
- FB_DEPTH, 4, number of pair entries; power of 2, at least 2.
- NOP_INST, 32'h0000_0013, pad instruction (ADDI x0,x0,0).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  redirect; discard all entries
- fetch_val  in  1  fetch group valid
- fetch_rdy  out  1  buffer can accept a group this cycle
- fetch_pc  in  CPU_ADDR_BITS  8-byte-aligned group PC (bits [2:0]=0)
- fetch_inst0  in  CPU_INST_BITS  instruction at fetch_pc
- fetch_inst1  in  CPU_INST_BITS  instruction at fetch_pc+4
- fetch_mask  in  2  slot valid bits; [0]=inst0, [1]=inst1
- decode_rdy  in  1  decode accepts pair
- inst_val  out  1  head pair valid
- inst0_pc  out  CPU_ADDR_BITS  PC of output slot 0
- inst1_pc  out  CPU_ADDR_BITS  inst0_pc+4
- inst0  out  CPU_INST_BITS  output slot 0
- inst1  out  CPU_INST_BITS  output slot 1
- fb_count  out  $clog2(FB_DEPTH)+1  occupied entries

Behaviour:
- Reset (rst_n=0, asynchronous): rd/wr pointers=0, count=0. Outputs: inst_val=0, fetch_rdy=1, fb_count=0. inst0/inst1/PCs read the head entry and are don't-care while inst_val=0.
- Pointers are $clog2(FB_DEPTH)+1 bits with a wrap bit.
  - empty = pointers equal.
  - full = index bits equal and wrap bits differ.
- Enqueue = fetch_val && fetch_rdy && fetch_mask!=0 && !flush. A group with mask 2'b00 is consumed and not written.
- Dequeue = inst_val && decode_rdy.
- fetch_rdy = !full. It does not depend on decode_rdy, so there is no combinational path from decode to fetch.
- Entry formation (combinational, at write):
  - mask 2'b11: pc=fetch_pc, slots {fetch_inst0, fetch_inst1}.
  - mask 2'b01: pc=fetch_pc, slots {fetch_inst0, NOP_INST}.
  - mask 2'b10: pc=fetch_pc+4, slots {fetch_inst1, NOP_INST}.
- Each entry stores pc, slot0 and slot1. inst1_pc is always computed as pc+4, modulo 2^CPU_ADDR_BITS.
- Output is first-word-fall-through: inst_val = !empty, and outputs are taken from the head entry.
- Latency without bypass: a group enqueued at edge N is visible at decode in cycle N+1.
- Enqueue and dequeue in the same cycle: count is unchanged. This is legal when full (fetch_rdy=0 blocks the enqueue anyway) and when holding 1 entry.
- Hold rule: while inst_val=1 && decode_rdy=0, all outputs stay stable.
- flush has priority. At the next edge: pointers reset, count=0, and any same-cycle enqueue is dropped. inst_val=0 in the cycle after flush.
- Reset asserted mid-operation: contents are lost immediately. The first enqueue after deassertion lands in entry 0.
- Wrap-around: pointer index rolls FB_DEPTH-1 → 0 and the wrap bit toggles; order is preserved.
- Storage is flops. No reset is required on entry payload.

Optional Feature:
- Macro: FETCH_BUFFER_BYPASS_EN.
- Defined, when empty && enqueue-eligible && !flush:
  - The formed entry is driven combinationally to the outputs and inst_val=1 in the same cycle.
  - If decode_rdy=1, the group is consumed and not written; count stays 0.
  - Otherwise it is written normally.
  - Zero-cycle latency when empty.
- Undefined: outputs come from storage only, with the one-cycle latency above.

Decomposition:
- uarch_pkg:
  - Add fb_entry_t {pc, slot0, slot1}.
  - Add constant INST_NOP = 32'h0000_0013.
  - Reuse CPU_ADDR_BITS and CPU_INST_BITS.
- Single module; no sub-module. Entry formation is a local function.

Test Plan:
- Reset then enqueue pc=0x100, inst0=0x00500093, inst1=0x00A00113, mask=11, decode_rdy=1 → next cycle inst_val=1, inst0_pc=0x100, inst1_pc=0x104, slots match; following cycle inst_val=0.
- mask=10, pc=0x208, fetch_inst1=0x00108093 → inst0_pc=0x20C, inst0=0x00108093, inst1=0x00000013, inst1_pc=0x210.
- decode_rdy=0 with 5 valid groups and FB_DEPTH=4:
  - fetch_rdy drops after 4 enqueues and fb_count=4.
  - Raise decode_rdy: pairs emerge in order with no loss or duplicate, across pointer wrap.
- Full buffer, flush=1 asserted with fetch_val=1 → next cycle fb_count=0, inst_val=0, fetch_rdy=1; the flushed-cycle group never appears.
- Streaming at 1 group/cycle with decode_rdy=1 and fb_count=1: fb_count stays at 1 every cycle. With FETCH_BUFFER_BYPASS_EN and starting empty: fb_count stays 0 and the group appears in the same cycle.
- Drop rst_n asynchronously mid-stream with 3 entries → outputs show inst_val=0 and fb_count=0 before the next clock edge; the first post-reset group appears normally.
